// File: rtl/rc4_plaintext_checker.sv
// Purpose: checks each decrypted RC4 byte is lowercase ASCII or space and reports a per-key verdict.
// Latency: deciding byte/core_done sampled at cycle N -> finish_decrypt pulse and valid at N+1.
// Backpressure: none; bytes are taken every cycle they are offered, ignored in HOLD until restart.
// Optional: define RC4_EARLY_ABORT_EN to report on the first bad byte and raise abort.
module rc4_plaintext_checker #(
    parameter int MSG_LEN = 32,
    parameter int ADDR_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              restart,
    input  logic              byte_valid,
    input  logic [ADDR_W-1:0] byte_addr,
    input  logic [7:0]        byte_data,
    input  logic              core_done,
    output logic              finish_decrypt,
    output logic              valid,
    output logic              abort,
    output logic [ADDR_W:0]   bytes_checked,
    output logic [ADDR_W-1:0] bad_addr
);

    typedef enum logic [1:0] {
        S_CHECK  = 2'd0,
        S_REPORT = 2'd1,
        S_HOLD   = 2'd2
    } state_t;

    localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(MSG_LEN - 1);
    localparam logic [ADDR_W:0] MSG_CNT  = (ADDR_W+1)'(MSG_LEN);

`ifdef RC4_EARLY_ABORT_EN
    localparam bit EARLY_ABORT = 1'b1;
`else
    localparam bit EARLY_ABORT = 1'b0;
`endif

    state_t              state_q, state_d;
    logic                fail_q, fail_d;
    logic [ADDR_W-1:0]   bad_addr_q, bad_addr_d;
    logic [ADDR_W:0]     cnt_q, cnt_d;
    logic                finish_q, finish_d;
    logic                valid_q, valid_d;
    logic                byte_legal;
    logic                byte_ok;
    logic                first_fail;
    logic                go_report;

    // A byte is legal when it is a space or lies in 'a'..'z'.
    assign byte_legal = (byte_data == 8'h20) ||
                        ((byte_data >= 8'h61) && (byte_data <= 8'h7A));

    // Next-state and verdict computation; restart overrides everything, including a same-cycle byte.
    always_comb begin
        state_d    = state_q;
        fail_d     = fail_q;
        bad_addr_d = bad_addr_q;
        cnt_d      = cnt_q;
        finish_d   = 1'b0;
        valid_d    = valid_q;
        byte_ok    = 1'b0;
        first_fail = 1'b0;
        go_report  = 1'b0;
        if (restart) begin
            state_d    = S_CHECK;
            fail_d     = 1'b0;
            bad_addr_d = '0;
            cnt_d      = '0;
            valid_d    = 1'b0;
        end else begin
            case (state_q)
                S_CHECK: begin
                    if (byte_valid) begin
                        byte_ok = byte_legal && ({1'b0, byte_addr} == cnt_q);
                        if (!byte_ok && !fail_q) begin
                            first_fail = 1'b1;
                            fail_d     = 1'b1;
                            bad_addr_d = byte_addr;
                        end
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q == LAST_IDX) begin
                            go_report = 1'b1;
                        end
                        if (EARLY_ABORT && first_fail) begin
                            go_report = 1'b1;
                        end
                    end
                    // The byte of this cycle is counted before judging a short message.
                    if (core_done && !go_report && (cnt_d < MSG_CNT)) begin
                        if (!fail_d) begin
                            fail_d     = 1'b1;
                            bad_addr_d = cnt_d[ADDR_W-1:0];
                        end
                        go_report = 1'b1;
                    end
                    if (go_report) begin
                        state_d  = S_REPORT;
                        finish_d = 1'b1;
                        valid_d  = ~fail_d;
                    end
                end
                S_REPORT: begin
                    state_d = S_HOLD;
                end
                S_HOLD: begin
                    state_d = S_HOLD;
                end
                default: begin
                    state_d = S_CHECK;
                end
            endcase
        end
    end

    // State and verdict registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_CHECK;
            fail_q     <= 1'b0;
            bad_addr_q <= '0;
            cnt_q      <= '0;
            finish_q   <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            fail_q     <= fail_d;
            bad_addr_q <= bad_addr_d;
            cnt_q      <= cnt_d;
            finish_q   <= finish_d;
            valid_q    <= valid_d;
        end
    end

`ifdef RC4_EARLY_ABORT_EN
    logic abort_q, abort_d;

    // Abort rises with a failing verdict and stays up until the next key is armed.
    always_comb begin
        abort_d = abort_q;
        if (restart) begin
            abort_d = 1'b0;
        end else if ((state_q == S_CHECK) && (state_d == S_REPORT) && fail_d) begin
            abort_d = 1'b1;
        end
    end

    // Abort register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            abort_q <= 1'b0;
        end else begin
            abort_q <= abort_d;
        end
    end

    assign abort = abort_q;
`else
    assign abort = 1'b0;
`endif

    assign finish_decrypt = finish_q;
    assign valid          = valid_q;
    assign bytes_checked  = cnt_q;
    assign bad_addr       = bad_addr_q;

endmodule
